if_prefetch_queue: RTL

//  Instruction prefetch buffer upstream of the IF/ID pipeline register.
//  - Issues sequential fetches to a 1-cycle-latency instruction memory.
//  - Buffers up to DEPTH {pc+4, instr} entries.
//  - Hands entries to IF/ID over a valid/ready handshake, so a stalled ID stage does not lose fetches.
//  - A branch redirect from MEM flushes the queue and restarts fetch at the target.

---
 rtl/if_prefetch_queue.sv | 91 +++++++++
 1 files changed

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue feeding IF/ID: sequential fetch, FIFO buffering, redirect flush.
// Optional `PFQ_BYPASS_EN presents an arriving response on out_* when the queue is empty.
module if_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  output logic                     imem_req_o,
  output logic [31:0]              imem_addr_o,
  input  logic [31:0]              imem_rdata_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [31:0]              out_pc4_o,
  output logic [31:0]              out_instr_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } entry_t;

  entry_t [DEPTH-1:0] mem;
  entry_t             head;
  logic [31:0]        fetch_pc, inflight_pc4;
  logic               inflight;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               req, wr_en, rd_en;

  // Credit counts the in-flight fetch so a response always has a free slot.
  // Gating with rst_i keeps the request low while reset is held.
  assign req         = rst_i && !redirect_i && ((count + CW'(inflight)) < DEPTH_C);
  assign imem_req_o  = req;
  assign imem_addr_o = fetch_pc;
  assign count_o     = count;
  assign head        = mem[rd_ptr];

`ifdef PFQ_BYPASS_EN
  logic byp;
  assign byp         = (count == '0) && inflight && !redirect_i;
  assign out_valid_o = ((count != '0) && !redirect_i) || byp;
  assign out_pc4_o   = byp ? inflight_pc4 : head.pc4;
  assign out_instr_o = byp ? imem_rdata_i : head.instr;
  assign wr_en       = inflight && !redirect_i && !(byp && out_ready_i);
  assign rd_en       = out_valid_o && out_ready_i && !byp;
`else
  assign out_valid_o = (count != '0) && !redirect_i;
  assign out_pc4_o   = head.pc4;
  assign out_instr_o = head.instr;
  assign wr_en       = inflight && !redirect_i;
  assign rd_en       = out_valid_o && out_ready_i;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc     <= RESET_PC;
      inflight     <= 1'b0;
      inflight_pc4 <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      mem          <= '0;
    end else if (redirect_i) begin
      // Redirect wins: drop stored entries and the response still in flight.
      fetch_pc <= redirect_pc_i;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= req;
      if (req) begin
        fetch_pc     <= fetch_pc + 32'd4;
        inflight_pc4 <= fetch_pc + 32'd4;
      end
      if (wr_en) begin
        mem[wr_ptr] <= '{pc4: inflight_pc4, instr: imem_rdata_i};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end
endmodule
